// File: rtl/arty_rst_seq.sv
// -----------------------------------------------------------------------------
// arty_rst_seq : board-level reset and boot sequencer for the FPGA top.
//
// Holds every core reset domain in reset until the MMCM reports lock,
// stretches reset, releases NUM_RST active-low reset channels one after another
// STAGGER_CYCLES apart, waits FETCH_DELAY cycles and then passes a debounced
// fetch-enable switch to the core. Loss of lock or the user reset button
// restarts the whole sequence.
//
// Optional feature macro: ARTY_RST_SEQ_LOCKCNT_EN
//   defined   -> adds lock_loss_cnt_o[7:0], a saturating count of lock-loss
//                events, cleared only by rst_n.
//   undefined -> port and counter are absent; everything else is identical.
// -----------------------------------------------------------------------------
module arty_rst_seq #(
    parameter int NUM_RST         = 2,
    parameter int STRETCH_CYCLES  = 16,
    parameter int STAGGER_CYCLES  = 8,
    parameter int FETCH_DELAY     = 32,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pll_locked_i,
    input  logic               btn_rst_n_i,
    input  logic               fetch_en_i,
    output logic [NUM_RST-1:0] rst_n_o,
    output logic               fetch_enable_o,
    output logic [2:0]         seq_state_o,
    output logic               lock_lost_o
`ifdef ARTY_RST_SEQ_LOCKCNT_EN
    ,
    output logic [7:0]         lock_loss_cnt_o
`endif
);

    // Sequencer states; encodings are visible on seq_state_o.
    typedef enum logic [2:0] {
        ST_WAIT_LOCK  = 3'd0,
        ST_STRETCH    = 3'd1,
        ST_RELEASE    = 3'd2,
        ST_FETCH_WAIT = 3'd3,
        ST_RUN        = 3'd4
    } seq_state_t;

    localparam logic [CNT_W-1:0]   CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(1);
    // Last counter value spent in each timed phase.
    localparam logic [CNT_W-1:0]   STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0]   FETCH_LAST   = CNT_W'(FETCH_DELAY - 1);
    localparam logic [CNT_W-1:0]   DEB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Counter value at which the highest reset channel is released.
    localparam logic [CNT_W-1:0]   REL_LAST     = CNT_W'((NUM_RST - 1) * STAGGER_CYCLES);
    localparam logic [NUM_RST-1:0] RST_ASSERTED = {NUM_RST{1'b0}};

    // Channels whose release slot is exactly counter value tgt.
    function automatic logic [NUM_RST-1:0] release_mask(input logic [CNT_W-1:0] tgt);
        logic [NUM_RST-1:0] m;
        m = {NUM_RST{1'b0}};
        for (int i = 0; i < NUM_RST; i++) begin
            if (tgt == CNT_W'(i * STAGGER_CYCLES)) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    // Synchronizer flops.
    logic r_lock_meta;
    logic r_lock_sync;
    logic r_btn_meta;
    logic r_btn_sync;
    logic r_fen_meta;
    logic r_fen_sync;

    // Debouncer.
    logic             r_deb;
    logic [CNT_W-1:0] r_deb_cnt;

    // Sequencer state and registered outputs.
    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [NUM_RST-1:0] r_rst_n;
    logic [NUM_RST-1:0] w_rst_n_nxt;
    logic             r_fetch_en;
    logic             w_fetch_en_nxt;
    logic             r_lock_lost;
    logic             w_lock_lost_nxt;

    // Helper nets.
    logic             w_restart;
    logic             w_lock_loss_evt;
    logic [CNT_W-1:0] w_rel_tgt;
    logic [NUM_RST-1:0] w_rel_rst;
    logic             w_rel_done;

    // Either lock loss or a pressed button forces the sequence back to the start.
    assign w_restart       = ~r_lock_sync | ~r_btn_sync;
    // Lock drops while the sequence is under way (WAIT_LOCK already expects no lock).
    assign w_lock_loss_evt = ~r_lock_sync & (r_state != ST_WAIT_LOCK);
    assign w_lock_lost_nxt = r_lock_lost | w_lock_loss_evt;

    // Next release slot: slot 0 on entry from STRETCH, otherwise one past the current count.
    assign w_rel_tgt  = (r_state == ST_RELEASE) ? (r_cnt + CNT_ONE) : CNT_ZERO;
    assign w_rel_rst  = r_rst_n | release_mask(w_rel_tgt);
    assign w_rel_done = (w_rel_tgt == REL_LAST);

    // Two-flop synchronizers for the three asynchronous board inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
            r_btn_meta  <= 1'b0;
            r_btn_sync  <= 1'b0;
            r_fen_meta  <= 1'b0;
            r_fen_sync  <= 1'b0;
        end else begin
            r_lock_meta <= pll_locked_i;
            r_lock_sync <= r_lock_meta;
            r_btn_meta  <= btn_rst_n_i;
            r_btn_sync  <= r_btn_meta;
            r_fen_meta  <= fetch_en_i;
            r_fen_sync  <= r_fen_meta;
        end
    end

    // Debounce: the output flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deb     <= 1'b0;
            r_deb_cnt <= CNT_ZERO;
        end else if (r_fen_sync == r_deb) begin
            r_deb_cnt <= CNT_ZERO;
        end else if (r_deb_cnt == DEB_LAST) begin
            r_deb     <= ~r_deb;
            r_deb_cnt <= CNT_ZERO;
        end else begin
            r_deb_cnt <= r_deb_cnt + CNT_ONE;
        end
    end

    // Next-state, counter and next-output decode; restart outranks every other transition.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_rst_n_nxt    = r_rst_n;
        w_fetch_en_nxt = 1'b0;
        if (w_restart && (r_state != ST_WAIT_LOCK)) begin
            w_state_nxt = ST_WAIT_LOCK;
            w_cnt_nxt   = CNT_ZERO;
            w_rst_n_nxt = RST_ASSERTED;
        end else begin
            case (r_state)
                ST_WAIT_LOCK: begin
                    w_rst_n_nxt = RST_ASSERTED;
                    w_cnt_nxt   = CNT_ZERO;
                    if (!w_restart) begin
                        w_state_nxt = ST_STRETCH;
                    end else begin
                        w_state_nxt = ST_WAIT_LOCK;
                    end
                end
                ST_STRETCH: begin
                    if (r_cnt == STRETCH_LAST) begin
                        // Channel 0 comes out of reset on the same edge RELEASE is entered.
                        w_rst_n_nxt = w_rel_rst;
                        if (w_rel_done) begin
                            w_state_nxt = ST_FETCH_WAIT;
                            w_cnt_nxt   = CNT_ZERO;
                        end else begin
                            w_state_nxt = ST_RELEASE;
                            w_cnt_nxt   = w_rel_tgt;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                ST_RELEASE: begin
                    w_rst_n_nxt = w_rel_rst;
                    if (w_rel_done) begin
                        w_state_nxt = ST_FETCH_WAIT;
                        w_cnt_nxt   = CNT_ZERO;
                    end else begin
                        w_state_nxt = ST_RELEASE;
                        w_cnt_nxt   = w_rel_tgt;
                    end
                end
                ST_FETCH_WAIT: begin
                    if (r_cnt == FETCH_LAST) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = CNT_ZERO;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    w_cnt_nxt      = CNT_ZERO;
                    w_fetch_en_nxt = r_deb;
                end
                default: begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = CNT_ZERO;
                    w_rst_n_nxt = RST_ASSERTED;
                end
            endcase
        end
    end

    // Sequencer state, counter and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_WAIT_LOCK;
            r_cnt       <= CNT_ZERO;
            r_rst_n     <= RST_ASSERTED;
            r_fetch_en  <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rst_n     <= w_rst_n_nxt;
            r_fetch_en  <= w_fetch_en_nxt;
            r_lock_lost <= w_lock_lost_nxt;
        end
    end

`ifdef ARTY_RST_SEQ_LOCKCNT_EN
    logic [7:0] r_lock_cnt;

    // Saturating count of lock-loss events since the last board reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_cnt <= 8'd0;
        end else if (w_lock_loss_evt && (r_lock_cnt != 8'd255)) begin
            r_lock_cnt <= r_lock_cnt + 8'd1;
        end else begin
            r_lock_cnt <= r_lock_cnt;
        end
    end

    assign lock_loss_cnt_o = r_lock_cnt;
`endif

    assign rst_n_o        = r_rst_n;
    assign fetch_enable_o = r_fetch_en;
    assign seq_state_o    = r_state;
    assign lock_lost_o    = r_lock_lost;

endmodule

// File: tb/tb_arty_rst_seq.sv
// -----------------------------------------------------------------------------
// Self-checking bench for arty_rst_seq. Expected output vectors are built from
// the timeline of the boot sequence, queued when stimulus is applied and popped
// and compared once the DUT has clocked. A second instance with four channels
// and a one-cycle stagger exercises back-to-back releases.
// -----------------------------------------------------------------------------
module tb_arty_rst_seq;

    localparam int NR    = 2;
    localparam int STR   = 16;
    localparam int STG   = 8;
    localparam int FD    = 32;
    localparam int DB    = 1000;
    localparam int NR2   = 4;
    localparam int STG2  = 1;

    // Cycle (edges after inputs become good) at which each phase starts.
    localparam int T_STR   = 3;
    localparam int T_REL   = T_STR + STR;
    localparam int T_FW    = T_REL + (NR - 1) * STG;
    localparam int T_RUN   = T_FW + FD;
    localparam int T2_FW   = T_REL + (NR2 - 1) * STG2;
    localparam int T2_RUN  = T2_FW + FD;

    logic           clk;
    logic           rst_n;
    logic           rst2_n;
    logic           locked;
    logic           btn;
    logic           fen;
    logic [NR-1:0]  o_rst;
    logic           o_fe;
    logic [2:0]     o_st;
    logic           o_ll;
    logic [NR2-1:0] o2_rst;
    logic           o2_fe;
    logic [2:0]     o2_st;
    logic           o2_ll;
`ifdef ARTY_RST_SEQ_LOCKCNT_EN
    logic [7:0]     o_lcnt;
    logic [7:0]     o2_lcnt;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] e;

    arty_rst_seq #(
        .NUM_RST(NR), .STRETCH_CYCLES(STR), .STAGGER_CYCLES(STG),
        .FETCH_DELAY(FD), .DEBOUNCE_CYCLES(DB), .CNT_W(16)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .pll_locked_i(locked), .btn_rst_n_i(btn),
        .fetch_en_i(fen), .rst_n_o(o_rst), .fetch_enable_o(o_fe),
        .seq_state_o(o_st), .lock_lost_o(o_ll)
`ifdef ARTY_RST_SEQ_LOCKCNT_EN
        , .lock_loss_cnt_o(o_lcnt)
`endif
    );

    arty_rst_seq #(
        .NUM_RST(NR2), .STRETCH_CYCLES(STR), .STAGGER_CYCLES(STG2),
        .FETCH_DELAY(FD), .DEBOUNCE_CYCLES(DB), .CNT_W(16)
    ) u_dut4 (
        .clk(clk), .rst_n(rst2_n), .pll_locked_i(locked), .btn_rst_n_i(btn),
        .fetch_en_i(fen), .rst_n_o(o2_rst), .fetch_enable_o(o2_fe),
        .seq_state_o(o2_st), .lock_lost_o(o2_ll)
`ifdef ARTY_RST_SEQ_LOCKCNT_EN
        , .lock_loss_cnt_o(o2_lcnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {state, rst_n_o, fetch_enable_o, lock_lost_o} of the 2-channel DUT,
    // t edges after the inputs became good. fe_ok: debounced switch was 1 one cycle earlier.
    function automatic logic [15:0] exp1(input int t, input logic fe_ok, input logic ll);
        logic [2:0] st;
        logic [1:0] r;
        logic       fe;
        if (t < T_STR)      begin st = 3'd0; r = 2'b00; end
        else if (t < T_REL) begin st = 3'd1; r = 2'b00; end
        else if (t < T_FW)  begin st = 3'd2; r = 2'b01; end
        else if (t < T_RUN) begin st = 3'd3; r = 2'b11; end
        else                begin st = 3'd4; r = 2'b11; end
        fe = fe_ok && (t >= T_RUN + 1);
        return {9'd0, st, r, fe, ll};
    endfunction

    // Expected vector of the 4-channel, 1-cycle-stagger DUT.
    function automatic logic [15:0] exp2(input int t);
        logic [2:0] st;
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 0; i < NR2; i++) begin
            if (t >= T_REL + i * STG2) r[i] = 1'b1;
        end
        if (t < T_STR)       st = 3'd0;
        else if (t < T_REL)  st = 3'd1;
        else if (t < T2_FW)  st = 3'd2;
        else if (t < T2_RUN) st = 3'd3;
        else                 st = 3'd4;
        return {7'd0, st, r, 1'b0, 1'b0};
    endfunction

    function automatic logic [15:0] act1();
        return {9'd0, o_st, o_rst, o_fe, o_ll};
    endfunction

    function automatic logic [15:0] act2();
        return {7'd0, o2_st, o2_rst, o2_fe, o2_ll};
    endfunction

    // One clock; outputs are then sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst2_n = 1'b0; locked = 1'b1; btn = 1'b1; fen = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(16'h0000);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (act1() !== e) begin errors++; $display("FAIL reset dut2ch got=%h exp=%h", act1(), e); end
            checks++;
            if (act2() !== 16'h0000) begin errors++; $display("FAIL reset dut4ch got=%h exp=0000", act2()); end
        end
`ifdef ARTY_RST_SEQ_LOCKCNT_EN
        checks++;
        if (o_lcnt !== 8'd0) begin errors++; $display("FAIL reset lcnt got=%0d exp=0", o_lcnt); end
`endif
    endtask

    // Boot sequence with the switch on from the start; fetch enable waits for the debouncer.
    task automatic test_sequence();
        rst_n = 1'b1;
        for (int t = 1; t <= DB + 10; t++) begin
            exp_q.push_back(exp1(t, t >= DB + 3, 1'b0));
            tick();
            e = exp_q.pop_front();
            checks++;
            if (act1() !== e) begin errors++; $display("FAIL sequence t=%0d got=%h exp=%h", t, act1(), e); end
        end
    endtask

    // A low pulse one cycle short of the debounce window must not reach the core.
    task automatic test_fetch_glitch();
        fen = 1'b0;
        for (int k = 1; k <= DB + 100; k++) begin
            exp_q.push_back(exp1(T_RUN + 5, 1'b1, 1'b0));
            tick();
            e = exp_q.pop_front();
            checks++;
            if (act1() !== e) begin errors++; $display("FAIL glitch k=%0d got=%h exp=%h", k, act1(), e); end
            if (k == DB - 1) fen = 1'b1;
        end
    endtask

    // A low pulse of exactly the debounce window drops fetch enable, then it recovers.
    task automatic test_fetch_drop();
        fen = 1'b0;
        for (int k = 1; k <= 2 * DB + 100; k++) begin
            exp_q.push_back(exp1(T_RUN + 5, !(k >= DB + 3 && k < 2 * DB + 3), 1'b0));
            tick();
            e = exp_q.pop_front();
            checks++;
            if (act1() !== e) begin errors++; $display("FAIL fetch_drop k=%0d got=%h exp=%h", k, act1(), e); end
            if (k == DB) fen = 1'b1;
        end
    endtask

    // Lock loss in RUN: everything drops three cycles later, flag sticks, sequence reruns.
    task automatic test_lock_loss();
        locked = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            exp_q.push_back((k < 3) ? exp1(T_RUN + 5, 1'b1, 1'b0) : exp1(0, 1'b0, 1'b1));
            tick();
            e = exp_q.pop_front();
            checks++;
            if (act1() !== e) begin errors++; $display("FAIL lock_drop k=%0d got=%h exp=%h", k, act1(), e); end
        end
        locked = 1'b1;
        for (int t = 1; t <= T_RUN + 5; t++) begin
            exp_q.push_back(exp1(t, 1'b1, 1'b1));
            tick();
            e = exp_q.pop_front();
            checks++;
            if (act1() !== e) begin errors++; $display("FAIL lock_rerun t=%0d got=%h exp=%h", t, act1(), e); end
        end
`ifdef ARTY_RST_SEQ_LOCKCNT_EN
        checks++;
        if (o_lcnt !== 8'd1) begin errors++; $display("FAIL lock_cnt got=%0d exp=1", o_lcnt); end
`endif
    endtask

    // Button in RELEASE after channel 0 is out: all drop, no lock flag, restart on release.
    task automatic test_button();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int t = 1; t <= T_REL + 1; t++) begin
            exp_q.push_back(exp1(t, 1'b0, 1'b0));
            tick();
            e = exp_q.pop_front();
            checks++;
            if (act1() !== e) begin errors++; $display("FAIL btn_pre t=%0d got=%h exp=%h", t, act1(), e); end
        end
        btn = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            exp_q.push_back((k < 3) ? exp1(T_REL + 1 + k, 1'b0, 1'b0) : exp1(0, 1'b0, 1'b0));
            tick();
            e = exp_q.pop_front();
            checks++;
            if (act1() !== e) begin errors++; $display("FAIL btn_hold k=%0d got=%h exp=%h", k, act1(), e); end
        end
        btn = 1'b1;
        for (int t = 1; t <= T_FW + 13; t++) begin
            exp_q.push_back(exp1(t, 1'b0, 1'b0));
            tick();
            e = exp_q.pop_front();
            checks++;
            if (act1() !== e) begin errors++; $display("FAIL btn_rerun t=%0d got=%h exp=%h", t, act1(), e); end
        end
    endtask

    // Board reset asserted mid-cycle in FETCH_WAIT: outputs clear without waiting for a clock.
    task automatic test_async_reset();
        checks++;
        if (o_st !== 3'd3) begin errors++; $display("FAIL async_pre state got=%0d exp=3", o_st); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (act1() !== 16'h0000) begin errors++; $display("FAIL async_now got=%h exp=0000", act1()); end
`ifdef ARTY_RST_SEQ_LOCKCNT_EN
        checks++;
        if (o_lcnt !== 8'd0) begin errors++; $display("FAIL async_lcnt got=%0d exp=0", o_lcnt); end
`endif
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(16'h0000);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (act1() !== e) begin errors++; $display("FAIL async_hold got=%h exp=%h", act1(), e); end
        end
        rst_n = 1'b1;
        for (int t = 1; t <= T_REL + 2; t++) begin
            exp_q.push_back(exp1(t, 1'b0, 1'b0));
            tick();
            e = exp_q.pop_front();
            checks++;
            if (act1() !== e) begin errors++; $display("FAIL async_rerun t=%0d got=%h exp=%h", t, act1(), e); end
        end
    endtask

    // Four channels one cycle apart; FETCH_WAIT starts with the last release.
    task automatic test_back_to_back();
        rst2_n = 1'b1;
        for (int t = 1; t <= T2_RUN + 5; t++) begin
            exp_q.push_back(exp2(t));
            tick();
            e = exp_q.pop_front();
            checks++;
            if (act2() !== e) begin errors++; $display("FAIL stagger4 t=%0d got=%h exp=%h", t, act2(), e); end
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_fetch_glitch();
        test_fetch_drop();
        test_lock_loss();
        test_button();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Time bound in case the bench itself stalls.
    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
